// File: rtl/seg_mux_capture.sv
// -----------------------------------------------------------------------------
// seg_mux_capture
//   Receive end of a dual-digit time-multiplexed 7-segment bus. The enables and
//   segments are synchronised, then a word must hold steady for SETTLE_CYCLES
//   consecutive samples before it is captured. A captured pattern is decoded
//   back to its hex nibble and stored in the digit register selected by the
//   enable. Once both digits have been captured, the pair is offered to a
//   consumer through valid/ack.
//
// Optional feature:
//   SEG_CAPTURE_ERRCNT_EN  when defined, err_count is a saturating count of err
//                          pulses. When undefined, err_count is tied to zero.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous active-high reset, clears all state
//   en_n       in   2  digit enables, active-low (bit0 = digit0, bit1 = digit1)
//   seg        in   7  segments, active-low (bit0 = a ... bit6 = g)
//   ack        in   1  consumer accepts the current pair (only while valid=1)
//   digit0     out  4  last decoded digit0 nibble
//   digit1     out  4  last decoded digit1 nibble
//   sum        out  5  digit0 + digit1
//   valid      out  1  both digits captured since the last accepted pair
//   err        out  1  one-cycle pulse: illegal enable or undecodable pattern
//   err_count  out  8  saturating error count (zero unless feature enabled)
// -----------------------------------------------------------------------------
module seg_mux_capture #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] en_n,
   input  logic [6:0] seg,
   input  logic       ack,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [4:0] sum,
   output logic       valid,
   output logic       err,
   output logic [7:0] err_count
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   // Returns {decodable, nibble} for an active-low segment pattern.
   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      logic [4:0] d;
      case (s)
         7'h40:   d = 5'h10;
         7'h79:   d = 5'h11;
         7'h24:   d = 5'h12;
         7'h30:   d = 5'h13;
         7'h19:   d = 5'h14;
         7'h12:   d = 5'h15;
         7'h02:   d = 5'h16;
         7'h78:   d = 5'h17;
         7'h00:   d = 5'h18;
         7'h10:   d = 5'h19;
         7'h08:   d = 5'h1A;
         7'h03:   d = 5'h1B;
         7'h46:   d = 5'h1C;
         7'h21:   d = 5'h1D;
         7'h06:   d = 5'h1E;
         7'h0E:   d = 5'h1F;
         default: d = 5'h00;
      endcase
      return d;
   endfunction

   // p0/p1 form the synchroniser; p2 is the previous synchronised sample.
   logic [1:0]     r_en_p0, r_en_p1, r_en_p2;
   logic [6:0]     r_seg_p0, r_seg_p1, r_seg_p2;
   state_t         r_state, w_state_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;
   logic [3:0]     r_d0, r_d1, w_d0_nx, w_d1_nx;
   logic [1:0]     r_mask, w_mask_nx;
   logic           r_err, w_err_nx;
   logic           w_changed, w_capture, w_illegal;
   logic [4:0]     w_dec;

   assign valid  = (r_mask == 2'b11);
   assign digit0 = r_d0;
   assign digit1 = r_d1;
   assign sum    = {1'b0, r_d0} + {1'b0, r_d1};
   assign err    = r_err;

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_capture  = 1'b0;
      w_illegal  = 1'b0;
      w_changed  = ({r_en_p1, r_seg_p1} != {r_en_p2, r_seg_p2});

      if (r_en_p1 == 2'b11) begin
         w_state_nx = S_IDLE;
         w_cnt_nx   = '0;
      end else if (r_en_p1 == 2'b00) begin
         // Flag only the first cycle of a both-driven episode so a long
         // contention burst produces a single error pulse.
         w_state_nx = S_IDLE;
         w_cnt_nx   = '0;
         w_illegal  = (r_en_p2 != 2'b00);
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nx = S_SETTLE;
               w_cnt_nx   = CNT_W'(1);
            end
            S_SETTLE: begin
               if (w_changed) begin
                  w_state_nx = S_SETTLE;
                  w_cnt_nx   = CNT_W'(1);
               end else if ((r_cnt + CNT_W'(1)) == CNT_W'(SETTLE_CYCLES)) begin
                  w_capture  = 1'b1;
                  w_state_nx = S_HOLD;
                  w_cnt_nx   = '0;
               end else begin
                  w_cnt_nx   = r_cnt + CNT_W'(1);
               end
            end
            S_HOLD: begin
               if (w_changed) begin
                  w_state_nx = S_SETTLE;
                  w_cnt_nx   = CNT_W'(1);
               end
            end
            default: begin
               w_state_nx = S_IDLE;
               w_cnt_nx   = '0;
            end
         endcase

         // With a one-sample settle window, the first sample already settles.
         if (SETTLE_CYCLES == 1 && w_state_nx == S_SETTLE) begin
            w_capture  = 1'b1;
            w_state_nx = S_HOLD;
            w_cnt_nx   = '0;
         end
      end
   end

   always_comb begin
      w_dec     = seg_decode(r_seg_p1);
      w_d0_nx   = r_d0;
      w_d1_nx   = r_d1;
      // Acceptance clears first so a capture on the same edge starts a new pair.
      w_mask_nx = (ack && valid) ? 2'b00 : r_mask;
      w_err_nx  = w_illegal || (w_capture && !w_dec[4]);
      if (w_capture && w_dec[4]) begin
         if (r_en_p1 == 2'b10) begin
            w_d0_nx      = w_dec[3:0];
            w_mask_nx[0] = 1'b1;
         end else begin
            w_d1_nx      = w_dec[3:0];
            w_mask_nx[1] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_en_p0  <= 2'b11;
         r_en_p1  <= 2'b11;
         r_en_p2  <= 2'b11;
         r_seg_p0 <= 7'h7F;
         r_seg_p1 <= 7'h7F;
         r_seg_p2 <= 7'h7F;
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_d0     <= 4'd0;
         r_d1     <= 4'd0;
         r_mask   <= 2'b00;
         r_err    <= 1'b0;
      end else begin
         r_en_p0  <= en_n;
         r_seg_p0 <= seg;
         r_en_p1  <= r_en_p0;
         r_seg_p1 <= r_seg_p0;
         r_en_p2  <= r_en_p1;
         r_seg_p2 <= r_seg_p1;
         r_state  <= w_state_nx;
         r_cnt    <= w_cnt_nx;
         r_d0     <= w_d0_nx;
         r_d1     <= w_d1_nx;
         r_mask   <= w_mask_nx;
         r_err    <= w_err_nx;
      end
   end

`ifdef SEG_CAPTURE_ERRCNT_EN
   logic [7:0] r_err_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_err_cnt <= 8'd0;
      end else if (w_err_nx && (r_err_cnt != 8'hFF)) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign err_count = r_err_cnt;
`else
   assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_seg_mux_capture.sv
// -----------------------------------------------------------------------------
// tb_seg_mux_capture
//   Directed scenarios followed by randomized bus traffic. The reference model
//   tracks the bus as a sequence of synchronised words and the length of the
//   current run of identical words; a single-enable word is captured when its
//   run length reaches SETTLE.
// -----------------------------------------------------------------------------
module tb_seg_mux_capture;

   localparam int SETTLE = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] en_n;
   logic [6:0] seg;
   logic       ack;
   logic [3:0] digit0, digit1;
   logic [4:0] sum;
   logic       valid, err;
   logic [7:0] err_count;

   seg_mux_capture #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk       (clk),
      .reset     (reset),
      .en_n      (en_n),
      .seg       (seg),
      .ack       (ack),
      .digit0    (digit0),
      .digit1    (digit1),
      .sum       (sum),
      .valid     (valid),
      .err       (err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [6:0] pat_tbl [16];

   // Model state: words are {en_n, seg}.
   logic [8:0] m_s1, m_s2, m_prev;
   int         m_run;
   logic [3:0] m_d0, m_d1;
   logic [1:0] m_mask;
   logic       m_err;
   int         m_ecnt;

   function automatic logic [4:0] ref_decode(input logic [6:0] s);
      logic [4:0] r;
      r = 5'h00;
      for (int i = 0; i < 16; i++)
         if (pat_tbl[i] == s) r = {1'b1, 4'(i)};
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      logic [8:0] w, pw;
      logic [4:0] dec;
      logic       single, cap, e;
      int         exp_cnt;
      w  = m_s2;
      pw = m_prev;
      if (reset) begin
         m_s1 = 9'h1FF; m_s2 = 9'h1FF; m_prev = 9'h1FF;
         m_run = 0; m_d0 = 0; m_d1 = 0; m_mask = 0; m_err = 0; m_ecnt = 0;
      end else begin
         if (w == pw) begin
            if (m_run < 1000) m_run++;
         end else begin
            m_run = 1;
         end
         single = (w[8:7] == 2'b10) || (w[8:7] == 2'b01);
         cap    = single && (m_run == SETTLE);
         dec    = ref_decode(w[6:0]);
         e      = ((w[8:7] == 2'b00) && (pw[8:7] != 2'b00)) || (cap && !dec[4]);
         if (ack && m_mask == 2'b11) m_mask = 2'b00;
         if (cap && dec[4]) begin
            if (w[8:7] == 2'b10) begin m_d0 = dec[3:0]; m_mask[0] = 1'b1; end
            else                 begin m_d1 = dec[3:0]; m_mask[1] = 1'b1; end
         end
         m_err = e;
         if (e && m_ecnt < 255) m_ecnt++;
         m_prev = m_s2;
         m_s2   = m_s1;
         m_s1   = {en_n, seg};
      end
      @(posedge clk);
      #1;
`ifdef SEG_CAPTURE_ERRCNT_EN
      exp_cnt = m_ecnt;
`else
      exp_cnt = 0;
`endif
      check("digit0", 32'(digit0), 32'(m_d0));
      check("digit1", 32'(digit1), 32'(m_d1));
      check("sum", 32'(sum), 32'(m_d0) + 32'(m_d1));
      check("valid", 32'(valid), 32'(m_mask == 2'b11));
      check("err", 32'(err), 32'(m_err));
      check("err_count", 32'(err_count), 32'(exp_cnt));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int pulses;
      int kind, len, exp_final;
      pat_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      m_s1 = 9'h1FF; m_s2 = 9'h1FF; m_prev = 9'h1FF;
      m_run = 0; m_d0 = 0; m_d1 = 0; m_mask = 0; m_err = 0; m_ecnt = 0;

      // Reset with idle bus
      reset = 1'b1; en_n = 2'b11; seg = 7'h7F; ack = 1'b0;
      ticks(3);
      reset = 1'b0;
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);

      // digit0 = 3 lands on exactly the sixth edge
      en_n = 2'b10; seg = 7'h30;
      ticks(5);
      check("d0_before_settle", 32'(digit0), 32'd0);
      tick();
      check("d0_after_6_edges", 32'(digit0), 32'd3);
      ticks(4);
      check("valid_one_digit", 32'(valid), 32'd0);

      // digit1 = F completes the pair
      en_n = 2'b01; seg = 7'h0E;
      ticks(10);
      check("d1_F", 32'(digit1), 32'hF);
      check("sum_18", 32'(sum), 32'd18);
      check("valid_pair", 32'(valid), 32'd1);

      // Toggling segments never settle
      en_n = 2'b10;
      for (int i = 0; i < 4; i++) begin
         seg = (i % 2 == 0) ? 7'h30 : 7'h19;
         ticks(3);
      end
      check("toggle_d0_hold", 32'(digit0), 32'd3);

      // Both enables driven: one error pulse only
      en_n = 2'b00; seg = 7'h30;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         pulses += int'(err);
      end
      check("illegal_pulses", 32'(pulses), 32'd1);
      en_n = 2'b11; seg = 7'h7F;
      ticks(4);

      // Blank pattern settles but is not decodable
      en_n = 2'b10; seg = 7'h7F;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         pulses += int'(err);
      end
      check("blank_pulses", 32'(pulses), 32'd1);
      check("blank_d0_hold", 32'(digit0), 32'd3);
      check("blank_valid_hold", 32'(valid), 32'd1);

      // ack lands on the same edge as a digit0 = 7 capture
      seg = 7'h78;
      ticks(5);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("ack_cap_valid", 32'(valid), 32'd0);
      check("ack_cap_d0", 32'(digit0), 32'd7);
      en_n = 2'b01; seg = 7'h79;
      ticks(10);
      check("reassert_valid", 32'(valid), 32'd1);
      check("reassert_d1", 32'(digit1), 32'd1);

      // Reset in the middle of settling
      en_n = 2'b10; seg = 7'h40;
      ticks(5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midsettle_d0", 32'(digit0), 32'd0);
      check("midsettle_valid", 32'(valid), 32'd0);
      en_n = 2'b11; seg = 7'h7F;
      ticks(3);

      // Randomized traffic
      for (int s = 0; s < 300; s++) begin
         kind = int'($urandom_range(0, 9));
         len  = int'($urandom_range(1, 8));
         if (kind == 0) begin
            en_n = 2'b11; seg = 7'h7F;
         end else if (kind == 1) begin
            en_n = 2'b00; seg = 7'($urandom);
         end else if (kind == 2) begin
            en_n = $urandom_range(0, 1) ? 2'b10 : 2'b01; seg = 7'($urandom);
         end else begin
            en_n = $urandom_range(0, 1) ? 2'b10 : 2'b01;
            seg  = pat_tbl[$urandom_range(0, 15)];
         end
         for (int c = 0; c < len; c++) begin
            ack   = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
         end
      end
      ack = 1'b0; reset = 1'b0;

      // Error counter saturation
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 260; i++) begin
         en_n = 2'b00; seg = 7'h7F;
         ticks(2);
         en_n = 2'b11;
         ticks(2);
      end
`ifdef SEG_CAPTURE_ERRCNT_EN
      exp_final = 255;
`else
      exp_final = 0;
`endif
      check("err_count_final", 32'(err_count), 32'(exp_final));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
